// File: rtl/dsi_clk_div_pkg.sv
// Shared types and helpers for the multi-channel DSI clock divider.
package dsi_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ch_state_e;

    localparam int unsigned MIN_DIV_DEF = 2;

    function automatic int unsigned clamp_ratio(input int unsigned r, input int unsigned min_div);
        return (r < min_div) ? min_div : r;
    endfunction

    // Result is wider than DIV_W so that N = 2^DIV_W-1 cannot wrap.
    function automatic int unsigned high_cnt(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/dsi_clk_div_ch.sv
// One divider channel: IDLE/RUN/STOP FSM, period counter, shadow ratio and output flops.
module dsi_clk_div_ch
    import dsi_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             ch_en,
    input  logic             sync,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             dsi_clk,
    output logic             clk_stb,
    output logic             ch_active,
    output logic             ratio_upd
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ns_q, ns_d;
    logic             clk_q, clk_d;
    logic             stb_q, stb_d;
    logic             upd_q, upd_d;
    logic             load;
    logic             wrap;
    logic [DIV_W-1:0] ratio_cl;

    assign ratio_cl = DIV_W'(clamp_ratio(32'(div_ratio), MIN_DIV));
    assign wrap     = (cnt_q == ns_q - DIV_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + DIV_W'(1);
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ch_en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // sync and a natural wrap share one boundary, so they can never double-strobe
                if (wrap || sync) begin
                    cnt_d = '0;
                    if (ch_en) load    = 1'b1;
                    else       state_d = IDLE;
                end else if (!ch_en) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d = '0;
                    if (ch_en) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ch_en) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ns_d  = load ? ratio_cl : ns_q;
        upd_d = load && (ratio_cl != ns_q);
        // Outputs are computed from next-state values so they leave flops aligned with cnt_q.
        clk_d = (state_d != IDLE) && (32'(cnt_d) < high_cnt(32'(ns_d)));
        stb_d = (state_d != IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ns_q    <= DIV_W'(MIN_DIV);
            clk_q   <= 1'b0;
            stb_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ns_q    <= ns_d;
            clk_q   <= clk_d;
            stb_q   <= stb_d;
            upd_q   <= upd_d;
        end
    end

    assign dsi_clk   = clk_q;
    assign clk_stb   = stb_q;
    assign ratio_upd = upd_q;
    assign ch_active = (state_q != IDLE);

endmodule

// File: rtl/dsi_clk_div_mc.sv
// NUM_CH independent DSI bit/byte clock dividers sharing a global phase-realign sync.
module dsi_clk_div_mc
    import dsi_clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       dsi_clk,
    output logic [NUM_CH-1:0]       clk_stb,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ratio_upd
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dsi_clk_div_ch #(
            .DIV_W   (DIV_W),
            .MIN_DIV (MIN_DIV)
        ) u_ch (
            .pclk      (pclk),
            .presetn   (presetn),
            .ch_en     (ch_en[i]),
            .sync      (sync),
            .div_ratio (div_ratio[i*DIV_W +: DIV_W]),
            .dsi_clk   (dsi_clk[i]),
            .clk_stb   (clk_stb[i]),
            .ch_active (ch_active[i]),
            .ratio_upd (ratio_upd[i])
        );
    end

endmodule

// File: tb/tb_dsi_clk_div_mc.sv
// Directed bench for dsi_clk_div_mc: ch0 vector table plus hand sequences for stop/sync/reset corners.
module tb_dsi_clk_div_mc;

    logic        pclk;
    logic        presetn;
    logic [3:0]  ch_en;
    logic [31:0] div_ratio;
    logic        sync;
    logic [3:0]  dsi_clk, clk_stb, ch_active, ratio_upd;

    int n_cmp = 0;
    int n_bad = 0;

    dsi_clk_div_mc #(.NUM_CH(4), .DIV_W(8), .MIN_DIV(2)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .ch_en     (ch_en),
        .div_ratio (div_ratio),
        .sync      (sync),
        .dsi_clk   (dsi_clk),
        .clk_stb   (clk_stb),
        .ch_active (ch_active),
        .ratio_upd (ratio_upd)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] ratio;
        logic [3:0]  clk, stb, act, upd;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic en, input logic [7:0] r,
                                input logic c, input logic s, input logic a, input logic u);
        vec_t v;
        v.en    = {3'b000, en};
        v.ratio = {24'd0, r};
        v.clk   = {3'b000, c};
        v.stb   = {3'b000, s};
        v.act   = {3'b000, a};
        v.upd   = {3'b000, u};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] en, input logic [31:0] r, input logic s,
                        input logic [3:0] e_clk, input logic [3:0] e_stb,
                        input logic [3:0] e_act, input logic [3:0] e_upd, input string nm);
        ch_en     = en;
        div_ratio = r;
        sync      = s;
        @(posedge pclk);
        #1;
        chk({nm, ".dsi_clk"},   dsi_clk,   e_clk);
        chk({nm, ".clk_stb"},   clk_stb,   e_stb);
        chk({nm, ".ch_active"}, ch_active, e_act);
        chk({nm, ".ratio_upd"}, ratio_upd, e_upd);
        sync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        presetn   = 1'b0;
        ch_en     = '0;
        sync      = 1'b0;
        div_ratio = '0;
        #1;
        chk("reset.dsi_clk",   dsi_clk,   4'b0000);
        chk("reset.clk_stb",   clk_stb,   4'b0000);
        chk("reset.ch_active", ch_active, 4'b0000);
        chk("reset.ratio_upd", ratio_upd, 4'b0000);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    initial begin
        presetn   = 1'b0;
        ch_en     = '0;
        div_ratio = '0;
        sync      = 1'b0;

        // ch0 only: N=4, boundary change to 5, mid-period write of 0 ignored, clamps, stop
        tbl[0]  = mk(1, 4, 1, 1, 1, 1);
        tbl[1]  = mk(1, 4, 1, 0, 1, 0);
        tbl[2]  = mk(1, 4, 0, 0, 1, 0);
        tbl[3]  = mk(1, 4, 0, 0, 1, 0);
        tbl[4]  = mk(1, 4, 1, 1, 1, 0);
        tbl[5]  = mk(1, 4, 1, 0, 1, 0);
        tbl[6]  = mk(1, 4, 0, 0, 1, 0);
        tbl[7]  = mk(1, 4, 0, 0, 1, 0);
        tbl[8]  = mk(1, 5, 1, 1, 1, 1);
        tbl[9]  = mk(1, 5, 1, 0, 1, 0);
        tbl[10] = mk(1, 5, 1, 0, 1, 0);
        tbl[11] = mk(1, 5, 0, 0, 1, 0);
        tbl[12] = mk(1, 5, 0, 0, 1, 0);
        tbl[13] = mk(1, 5, 1, 1, 1, 0);
        tbl[14] = mk(1, 0, 1, 0, 1, 0);
        tbl[15] = mk(1, 0, 1, 0, 1, 0);
        tbl[16] = mk(1, 0, 0, 0, 1, 0);
        tbl[17] = mk(1, 0, 0, 0, 1, 0);
        tbl[18] = mk(1, 0, 1, 1, 1, 1);
        tbl[19] = mk(1, 0, 0, 0, 1, 0);
        tbl[20] = mk(1, 1, 1, 1, 1, 0);
        tbl[21] = mk(1, 1, 0, 0, 1, 0);
        tbl[22] = mk(1, 1, 1, 1, 1, 0);
        tbl[23] = mk(0, 1, 0, 0, 1, 0);
        tbl[24] = mk(0, 1, 0, 0, 0, 0);
        tbl[25] = mk(0, 1, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 26; i++)
            step(tbl[i].en, tbl[i].ratio, 1'b0, tbl[i].clk, tbl[i].stb, tbl[i].act, tbl[i].upd,
                 $sformatf("tbl[%0d]", i));

        // Ratio 4->6 written at cnt=1: takes effect at the boundary, rewrite of 6 gives no pulse
        do_reset();
        step(4'b0001, 32'd4, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "upd.c0");
        step(4'b0001, 32'd6, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "upd.c1");
        step(4'b0001, 32'd6, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "upd.c2");
        step(4'b0001, 32'd6, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "upd.c3");
        step(4'b0001, 32'd6, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "upd.n0");
        step(4'b0001, 32'd6, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "upd.n1");
        step(4'b0001, 32'd6, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "upd.n2");
        for (int k = 3; k < 6; k++)
            step(4'b0001, 32'd6, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, $sformatf("upd.n%0d", k));
        step(4'b0001, 32'd6, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "upd.rewrite");

        // N=8, ch_en dropped at cnt=1: full period completes, then idle
        do_reset();
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "stop.c0");
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "stop.c1");
        step(4'b0000, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "stop.c2");
        step(4'b0000, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "stop.c3");
        for (int k = 4; k < 8; k++)
            step(4'b0000, 32'd8, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, $sformatf("stop.c%0d", k));
        step(4'b0000, 32'd8, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "stop.idle0");
        step(4'b0000, 32'd8, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "stop.idle1");

        // Re-raise ch_en during STOP: no gap, next period starts on time
        do_reset();
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "rer.c0");
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rer.c1");
        step(4'b0000, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rer.c2");
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rer.c3");
        for (int k = 4; k < 8; k++)
            step(4'b0001, 32'd8, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, $sformatf("rer.c%0d", k));
        step(4'b0001, 32'd8, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "rer.wrap");

        // Two channels (4 and 6), sync at arbitrary phase, sync on a natural wrap,
        // sync on a STOP channel, and sync coinciding with a new enable
        do_reset();
        step(4'b0011, 32'h0000_0604, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0011, "sync.start");
        step(4'b0011, 32'h0000_0604, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, "sync.c1");
        step(4'b0011, 32'h0000_0604, 0, 4'b0010, 4'b0000, 4'b0011, 4'b0000, "sync.c2");
        step(4'b0011, 32'h0000_0604, 1, 4'b0011, 4'b0011, 4'b0011, 4'b0000, "sync.pulse");
        step(4'b0011, 32'h0000_0604, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, "sync.a1");
        step(4'b0011, 32'h0000_0604, 0, 4'b0010, 4'b0000, 4'b0011, 4'b0000, "sync.a2");
        step(4'b0011, 32'h0000_0604, 0, 4'b0000, 4'b0000, 4'b0011, 4'b0000, "sync.a3");
        step(4'b0011, 32'h0000_0604, 1, 4'b0011, 4'b0011, 4'b0011, 4'b0000, "sync.onwrap");
        step(4'b0011, 32'h0000_0604, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, "sync.nodbl");
        step(4'b0010, 32'h0000_0604, 0, 4'b0010, 4'b0000, 4'b0011, 4'b0000, "sync.ch0stop");
        step(4'b0010, 32'h0000_0604, 1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "sync.stopidle");
        step(4'b0110, 32'h0003_0604, 1, 4'b0110, 4'b0110, 4'b0110, 4'b0100, "sync.enrise");
        step(4'b0110, 32'h0003_0604, 0, 4'b0110, 4'b0000, 4'b0110, 4'b0000, "sync.e1");

        // Asynchronous reset in the middle of a high phase
        #2;
        presetn = 1'b0;
        #1;
        chk("async.dsi_clk",   dsi_clk,   4'b0000);
        chk("async.clk_stb",   clk_stb,   4'b0000);
        chk("async.ch_active", ch_active, 4'b0000);
        chk("async.ratio_upd", ratio_upd, 4'b0000);
        ch_en = '0;
        sync  = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        step(4'b0001, 32'd4, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "restart.c0");
        step(4'b0001, 32'd4, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "restart.c1");
        step(4'b0001, 32'd4, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "restart.c2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsi_clk_div_mc.md
Name: dsi_clk_div_mc

Overview:
- Synthesizable, parametrised successor to the single-output DSI clock generator.
- Produces NUM_CH independent DSI bit/byte clocks from pclk. Each channel has its own programmable integer divide ratio, glitch-free start/stop and boundary-aligned ratio updates.
- A global sync realigns all running channels.
- Sits between the DSI register block (which supplies enables and ratios) and the lane/PHY logic.

Parameters:
NUM_CH, 4, number of independent clock channels (1..8)
DIV_W, 8, width of each channel's divide-ratio field
MIN_DIV, 2, smallest legal ratio; ratio values below MIN_DIV are treated as MIN_DIV

Ports:
pclk  in  1  system clock; all logic on its rising edge
presetn  in  1  asynchronous active-low reset
ch_en  in  NUM_CH  per-channel run request
div_ratio  in  NUM_CH*DIV_W  channel i ratio N_i in bits [i*DIV_W +: DIV_W]; period = N_i pclk cycles
sync  in  1  one-cycle pulse; restarts phase of all active channels
dsi_clk  out  NUM_CH  divided clocks (registered, glitch-free)
clk_stb  out  NUM_CH  one-pclk pulse in each cycle where dsi_clk rises
ch_active  out  NUM_CH  channel in RUN or STOP
ratio_upd  out  NUM_CH  one-pclk pulse when a ratio different from the previous one is loaded

Behaviour:
- Reset (presetn=0, asynchronous)
  - All outputs are 0.
  - All channels go to IDLE. Counters are 0.
  - Shadow ratio is MIN_DIV.
  - Reset mid-period truncates the clock immediately.
- Per-channel registers
  - State: IDLE, RUN or STOP.
  - Counter cnt, DIV_W bits.
  - Shadow ratio Ns, DIV_W bits.
  - H = (Ns+1)>>1 (high phase; for odd N the high phase is the longer one).
- IDLE
  - Outputs: dsi_clk=0, clk_stb=0, ch_active=0.
  - If ch_en=1 at an edge: load Ns from div_ratio (clamped), cnt=0, go to RUN.
  - In the cycle after that edge: dsi_clk=1, clk_stb=1, ch_active=1. Latency is 1 pclk.
- RUN
  - cnt increments each cycle.
  - At cnt==Ns-1: wrap to 0 (period boundary) and reload Ns from div_ratio.
  - Registered output: dsi_clk = (cnt < H).
  - clk_stb=1 exactly in the cycles where cnt==0.
- Stopping
  - ch_en=0 sampled in RUN -> STOP.
  - STOP keeps counting and toggling until the next period boundary, then goes to IDLE with dsi_clk=0.
  - No runt pulse is ever produced. The last high phase is always a full H cycles.
  - ch_en=1 sampled in STOP -> back to RUN with no phase disturbance.
- div_ratio changes
  - Ignored mid-period. They take effect only at a period boundary or at IDLE->RUN.
  - ratio_upd pulses in the cycle the new Ns is first used, only if it differs from the previous Ns.
- sync
  - Acts as a forced period boundary for every channel in RUN or STOP: cnt=0, Ns reloaded, dsi_clk=1, clk_stb=1 in the next cycle.
  - A channel in STOP that receives sync goes to IDLE instead.
  - IDLE channels ignore sync.
  - sync coinciding with a natural wrap is the same single boundary; no double strobe.
- Simultaneous ch_en rise and sync
  - Treated as a normal start; phase 0 next cycle.
- Ratio clamp
  - Ratio 0 or 1 -> MIN_DIV.
  - Maximum ratio 2^DIV_W-1; counter never overflows.
- Channels are fully independent apart from sync.

Decomposition:
- Package dsi_clk_div_pkg holds:
  - ch_state_e enum {IDLE, RUN, STOP}
  - MIN_DIV default constant
  - function clamp_ratio()
  - function high_cnt(N) returning (N+1)>>1
- Sub-module dsi_clk_div_ch: one channel (FSM, counter, shadow ratio, output flops).
- Top instantiates dsi_clk_div_ch NUM_CH times in a generate loop and fans out sync.

Test Plan:
- Reset then ch_en[0]=1, N=4 -> dsi_clk[0] pattern 1100 repeating starting 1 cycle after en; clk_stb[0] every 4th cycle; ch_active[0]=1.
- Odd ratio N=5 -> high 3 cycles, low 2; period 5.
- N=0 and N=1 -> behave as N=2 (toggle every cycle).
- Change ratio 4->6 at cnt=1 -> current period finishes at 4 cycles; next period is 6; ratio_upd pulses once at that boundary; rewriting 6 gives no pulse.
- Drop ch_en at cnt=1 with N=8 -> clock runs through cnt=7, then stays 0; ch_active falls at the boundary.
- Re-raise ch_en during STOP -> continuous clock with no gap.
- Two channels (N=4, N=6) running; pulse sync at arbitrary phase -> both show dsi_clk=1 and clk_stb=1 in the next cycle and stay aligned.
- presetn low mid-high-phase -> all outputs 0 immediately.
- Release reset and re-enable -> normal restart.
